// File: rtl/bg_scroll_ctrl.sv
// Frame-synchronous background scroll sequencer: steps the row offset once per
// frame at the start of vertical blank and supplies the matching ROM base address.
module bg_scroll_ctrl #(
  parameter int unsigned ROWS   = 558,
  parameter int unsigned ROW_W  = 160,
  parameter int unsigned TICK_V = 480
) (
  input  logic        clk_25MHz,
  input  logic        rst,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        start,
  input  logic        pause,
  input  logic        stop,
  input  logic [1:0]  speed,
  output logic [9:0]  scroll_row,
  output logic [16:0] base_addr,
  output logic        frame_tick,
  output logic        running
);

  localparam int unsigned ROW_BITS  = 10;
  localparam int unsigned ADDR_BITS = 17;
  localparam logic [ROW_BITS-1:0]  ROW_MAX  = ROW_BITS'(ROWS - 1);
  localparam logic [ADDR_BITS-1:0] BASE_MAX = ADDR_BITS'((ROWS - 1) * ROW_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [1:0]          div;
  logic [1:0]          div_next;
  logic [1:0]          step;
  logic [ROW_BITS-1:0] row_next;
  logic                tick_now;

  assign tick_now = (h_cnt == '0) && (v_cnt == ROW_BITS'(TICK_V));

  // State register
  always_ff @(posedge clk_25MHz) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; stop has priority over every other control
  always_comb begin
    state_next = state;
    if (stop) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start)  state_next = RUN;
        RUN:     if (pause)  state_next = PAUSED;
        PAUSED:  if (!pause) state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // Offset/divider next values; speed only matters on a RUN tick
  always_comb begin
    row_next = scroll_row;
    div_next = div;
    step     = 2'd0;
    if (stop) begin
      row_next = ROW_MAX;
      div_next = 2'd0;
    end else if ((state == IDLE) && start) begin
      div_next = 2'd0;
    end else if ((state == RUN) && tick_now) begin
      div_next = div + 2'd1;
      case (speed)
        2'd0:    step = (div == 2'd3) ? 2'd1 : 2'd0;
        2'd1:    step = {1'b0, div[0]};
        2'd2:    step = 2'd1;
        default: step = 2'd2;
      endcase
      // Modulo-ROWS decrement without ever forming an out-of-range value
      if (step == 2'd1) begin
        row_next = (scroll_row == '0) ? ROW_MAX : scroll_row - ROW_BITS'(1);
      end else if (step == 2'd2) begin
        if (scroll_row == '0)
          row_next = ROW_MAX - ROW_BITS'(1);
        else if (scroll_row == ROW_BITS'(1))
          row_next = ROW_MAX;
        else
          row_next = scroll_row - ROW_BITS'(2);
      end
    end
  end

  // Registered outputs; base_addr trails scroll_row by one clock
  always_ff @(posedge clk_25MHz) begin
    if (rst) begin
      scroll_row <= ROW_MAX;
      div        <= 2'd0;
      base_addr  <= BASE_MAX;
      frame_tick <= 1'b0;
      running    <= 1'b0;
    end else begin
      scroll_row <= row_next;
      div        <= div_next;
      base_addr  <= ADDR_BITS'(scroll_row) * ADDR_BITS'(ROW_W);
      frame_tick <= tick_now;
      running    <= (state_next == RUN);
    end
  end

endmodule

// File: doc/bg_scroll_ctrl.md
# bg_scroll_ctrl

Frame-synchronous sequencer for the vertically scrolling background. Tracks the VGA raster and advances the background row offset exactly once per frame, at the start of vertical blank, so the image never tears mid-frame. Outputs both the row offset (0..557) and the precomputed ROM base address (row × 160) consumed by the background pixel generator. Run, pause, stop and scroll speed are controlled by the game logic.

## Interface
Parameters:
- `ROWS`, 558: background image height in ROM rows; offset range 0..ROWS-1.
- `ROW_W`, 160: ROM words per image row.
- `TICK_V`, 480: `v_cnt` value at which the frame tick fires, with `h_cnt == 0`.

Ports:
- `clk_25MHz`  in  1  pixel clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `h_cnt`  in  10  horizontal pixel counter from the VGA controller.
- `v_cnt`  in  10  vertical line counter from the VGA controller.
- `start`  in  1  single-cycle pulse: IDLE -> RUN.
- `pause`  in  1  level: while high, RUN is held in PAUSED.
- `stop`  in  1  single-cycle pulse: any state -> IDLE, offset restored.
- `speed`  in  2  scroll rate: 0 = 1 row per 4 frames, 1 = 1 row per 2 frames, 2 = 1 row per frame, 3 = 2 rows per frame.
- `scroll_row`  out  10  current row offset, 0..557.
- `base_addr`  out  17  `scroll_row × 160`, registered, 0..89120.
- `frame_tick`  out  1  one-cycle pulse per frame.
- `running`  out  1  high in RUN only.

## Operation
- Tick detect: `tick_now = (h_cnt == 0) && (v_cnt == TICK_V)`. This is true for exactly one pixel clock per 800×525 frame.
- States:
  - IDLE: reset state; offset held at 557.
  - RUN: offset advances on qualifying ticks.
  - PAUSED: offset and frame divider are frozen.
- Transitions are evaluated on every clock, in priority order:
  1. `stop` -> IDLE. Offset is set to 557 and the divider is cleared.
  2. IDLE & `start` -> RUN. The divider is cleared.
  3. RUN & `pause` -> PAUSED.
  4. PAUSED & !`pause` -> RUN.
  - `start` in RUN or PAUSED is ignored.
  - `start` asserted together with `pause` enters RUN. PAUSED follows on the next clock if `pause` is still high.
- Frame divider: a 2-bit `div` counter increments on every tick while in RUN and wraps 3 -> 0.
- Step qualification on a RUN tick, using the pre-increment value of `div`:
  - speed 0: step when `div == 3`.
  - speed 1: step when `div[0] == 1`.
  - speed 2: step of 1 on every tick.
  - speed 3: step of 2 on every tick.
- `speed` is sampled only on the tick clock. A change mid-frame has no effect until the next tick.
- Offset update is a modulo-558 decrement, so the image moves downward:
  - step 1: 0 -> 557, else row-1.
  - step 2: 1 -> 557, 0 -> 556, else row-2.
  - No intermediate value outside 0..557 is ever registered.
- `base_addr` is registered from `scroll_row` using 17-bit arithmetic, e.g. `(row<<7)+(row<<5)`. The value never exceeds 89120.
- `frame_tick` pulses on every tick in every state, including IDLE and PAUSED.
- A tick in the same cycle as `stop` produces `frame_tick` = 1 but no step. The offset goes to 557.

## Timing
- Reset values, on the first rising edge with `rst` = 1:
  - state IDLE, `div` = 0.
  - `scroll_row` = 557, `base_addr` = 89120.
  - `frame_tick` = 0, `running` = 0.
- `frame_tick`, `scroll_row` and `running` are registered. They change on the edge that samples `tick_now` or the control input, so latency is 1 clock.
- `base_addr` lags `scroll_row` by exactly 1 clock. Both are stable for the entire visible region (v_cnt 0..479).
- `rst` asserted mid-operation overrides all inputs on that edge.
- Control inputs are assumed synchronous to `clk_25MHz`. No internal synchronisation is done.

## Test plan
- Reset, then idle for 3 frames: `scroll_row` = 557, `base_addr` = 89120, `running` = 0, and `frame_tick` pulses once per 420000 clocks.
- `start`, speed 2, run 5 frames: `scroll_row` steps 557 -> 556 -> ... -> 552, changing only on tick edges; `base_addr` = 88320 one clock after reaching 552.
- Speed 0 from 557: the row reaches 556 only on the 4th tick after start and 555 on the 8th. Speed 1: it changes on ticks 2, 4, 6.
- Wrap check: force the row to 1 (run from start), then speed 3: next tick gives 557, then 555. At row 0 with speed 2, the next tick gives 557.
- Hold `pause` across 3 ticks in RUN: row and `div` are frozen and `frame_tick` still pulses. Release: stepping resumes with the same divider phase.
- `stop` on the tick cycle while at row 300: next clock row = 557, state IDLE, `frame_tick` = 1. `rst` mid-RUN gives all reset values on the next clock.
